// File: rtl/adc_meas_seq.sv
// Measurement sequencer for the 8-bit parallel ADC: generates ad_clk, runs a
// zero-offset calibration, then schedules periodic averaged measurements.
module adc_meas_seq #(
  parameter int CLK_DIV  = 4,
  parameter int CAL_LOG2 = 10,
  parameter int AVG_LOG2 = 4,
  parameter int MEAS_GAP = 1000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              recal,
  input  logic [7:0]        ad_data,
  output logic              ad_clk,
  output logic [7:0]        zero_code,
  output logic [7:0]        meas_code,
  output logic signed [8:0] meas_delta,
  output logic              meas_valid,
  output logic              cal_done,
  output logic              busy
);

  localparam int DATA_W   = 8;
  localparam int MAX_LOG2 = (CAL_LOG2 > AVG_LOG2) ? CAL_LOG2 : AVG_LOG2;
  localparam int ACC_W    = DATA_W + MAX_LOG2;
  localparam int CNT_W    = MAX_LOG2 + 1;
  localparam int DIV_W    = $clog2(CLK_DIV);
  localparam int GAP_W    = (MEAS_GAP > 1) ? $clog2(MEAS_GAP) : 1;
  localparam int GAP_LAST = (MEAS_GAP > 0) ? MEAS_GAP - 1 : 0;

  typedef enum logic [1:0] {IDLE, CAL, MEAS, GAP} state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   div, div_n;
  logic               strobe;
  logic [ACC_W-1:0]   acc, acc_sum;
  logic [CNT_W-1:0]   smp_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               recal_pend;
  logic               cal_last, meas_last, gap_last;
  logic               do_sample, cal_fin, meas_fin, consume, abort;
  logic [DATA_W-1:0]  cal_avg, meas_avg;

  function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum,
                                                  input int sh);
    logic [ACC_W-1:0] shifted;
    shifted = sum >> sh;
    return shifted[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W:0] code_delta(input logic [DATA_W-1:0] a,
                                                        input logic [DATA_W-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  // Free-running divider; ad_clk is registered from the next divider value
  assign div_n  = (div == DIV_W'(CLK_DIV - 1)) ? '0 : div + 1'b1;
  assign strobe = (div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      div    <= '0;
      ad_clk <= 1'b0;
    end else begin
      div    <= div_n;
      ad_clk <= (div_n < DIV_W'(CLK_DIV / 2));
    end
  end

  assign acc_sum   = acc + ACC_W'(ad_data);
  assign cal_avg   = avg_trunc(acc_sum, CAL_LOG2);
  assign meas_avg  = avg_trunc(acc_sum, AVG_LOG2);
  assign cal_last  = (smp_cnt == CNT_W'((2 ** CAL_LOG2) - 1));
  assign meas_last = (smp_cnt == CNT_W'((2 ** AVG_LOG2) - 1));
  assign gap_last  = (gap_cnt == GAP_W'(GAP_LAST));
  assign busy      = (state != IDLE);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n   = state;
    do_sample = 1'b0;
    cal_fin   = 1'b0;
    meas_fin  = 1'b0;
    consume   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (strobe && start) begin
          if (!cal_done || recal_pend) begin
            state_n = CAL;
            consume = 1'b1;
          end else begin
            state_n = MEAS;
          end
        end
      end
      CAL: begin
        if (!start) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else if (strobe) begin
          do_sample = 1'b1;
          if (cal_last) begin
            cal_fin = 1'b1;
            state_n = MEAS;
          end
        end
      end
      MEAS: begin
        if (!start) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else if (strobe) begin
          do_sample = 1'b1;
          if (meas_last) begin
            meas_fin = 1'b1;
            if (MEAS_GAP != 0) begin
              state_n = GAP;
            end else if (recal_pend) begin
              state_n = CAL;
              consume = 1'b1;
            end else begin
              state_n = MEAS;
            end
          end
        end
      end
      GAP: begin
        if (!start) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else if (strobe && gap_last) begin
          consume = recal_pend;
          state_n = recal_pend ? CAL : MEAS;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Accumulation, result registers and sticky flags
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      acc        <= '0;
      smp_cnt    <= '0;
      gap_cnt    <= '0;
      recal_pend <= 1'b0;
      zero_code  <= '0;
      meas_code  <= '0;
      meas_delta <= '0;
      meas_valid <= 1'b0;
      cal_done   <= 1'b0;
    end else begin
      if (abort || cal_fin || meas_fin) begin
        acc     <= '0;
        smp_cnt <= '0;
      end else if (do_sample) begin
        acc     <= acc_sum;
        smp_cnt <= smp_cnt + 1'b1;
      end

      if (state != GAP || abort)  gap_cnt <= '0;
      else if (strobe)            gap_cnt <= gap_last ? '0 : gap_cnt + 1'b1;

      if (consume)                         recal_pend <= 1'b0;
      else if (recal && state != CAL)      recal_pend <= 1'b1;

      meas_valid <= meas_fin;
      if (cal_fin) begin
        zero_code <= cal_avg;
        cal_done  <= 1'b1;
      end
      if (meas_fin) begin
        meas_code  <= meas_avg;
        meas_delta <= code_delta(meas_avg, zero_code);
      end
    end
  end

endmodule

// File: doc/adc_meas_seq.md
Name: adc_meas_seq

Overview:
Measurement sequencer for the 8-bit parallel ADC front end of the voltmeter. It generates the ADC sample clock and runs a zero-offset calibration pass. It then schedules periodic averaged measurements and hands each offset-corrected code to the voltage-scaling/display path with a one-cycle valid strobe. It owns the only ADC interface and is the single source of sampling timing.

Parameters:
CLK_DIV, 4, sys_clk cycles per ad_clk period; even, >= 2
CAL_LOG2, 10, log2 of samples averaged during calibration
AVG_LOG2, 4, log2 of samples averaged per measurement
MEAS_GAP, 1000, sample periods idled between measurements (0 allowed)

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset, synchronous, active-low
start  in  1  level; 1 = run sequencer, 0 = stop
recal  in  1  single-cycle pulse; request new calibration
ad_data  in  8  ADC output code, unsigned
ad_clk  out  1  ADC sample clock
zero_code  out  8  calibrated zero-input code
meas_code  out  8  latest averaged code
meas_delta  out  9  signed meas_code - zero_code (two's complement)
meas_valid  out  1  one-cycle strobe, meas_code/meas_delta updated
cal_done  out  1  a calibration has completed since reset
busy  out  1  state != IDLE

Behaviour:
- One clock, sys_clk. Reset is synchronous, active-low, sampled on the sys_clk rising edge. Reset values: all outputs 0, div=0, state IDLE, accumulators 0, recal_pend 0.
- Divider div counts 0..CLK_DIV-1 and wraps. It runs continuously after reset, independent of state.
- ad_clk = 1 while div < CLK_DIV/2, else 0. It is registered, with no combinational glitches.
- Sample strobe occurs on the cycle div == CLK_DIV-1. ad_data is captured only on a strobe.
- State IDLE: on the first strobe with start=1, go to CAL if cal_done=0 or recal_pend=1, else go to MEAS.
- State CAL: accumulate 2^CAL_LOG2 strobe samples into an (8+CAL_LOG2)-bit accumulator. The cycle after the last sample:
  - zero_code = acc >> CAL_LOG2 (truncate);
  - cal_done = 1 and recal_pend = 0;
  - accumulator is cleared and state goes to MEAS.
- State MEAS: accumulate 2^AVG_LOG2 samples. The cycle after the last sample:
  - meas_code = acc >> AVG_LOG2;
  - meas_delta = {1'b0,meas_code} - {1'b0,zero_code};
  - meas_valid = 1 for exactly one sys_clk;
  - go to GAP, or directly to MEAS when MEAS_GAP == 0.
- State GAP: count MEAS_GAP strobes. At expiry go to CAL if recal_pend, else to MEAS.
- recal pulse sets recal_pend in any state except CAL, where it is ignored. recal_pend is consumed only at GAP expiry, IDLE exit, or MEAS completion with MEAS_GAP==0.
- During recalibration, cal_done stays 1 and zero_code holds its old value until the new value is written.
- start=0 in CAL, MEAS or GAP: next cycle go to IDLE and clear the accumulator and sample count.
  - No meas_valid is issued and zero_code is not updated; the aborted pass is discarded.
  - cal_done and recal_pend are retained.
- start and the last-sample completion in the same cycle: the abort wins, so no update occurs.
- Synchronous reset mid-operation returns everything to reset values on the next edge, including cal_done=0.
- meas_code and meas_delta hold their values between strobes. meas_delta range is -255..+255.

Test Plan:
(Parameters for all scenarios: CLK_DIV=4, CAL_LOG2=2, AVG_LOG2=1, MEAS_GAP=2.)
- Reset released, start=0 -> ad_clk toggles with period 4 (high 2 / low 2); busy=0, all other outputs 0 indefinitely.
- start=1, ad_data 100,101,102,103 in CAL then 140,142 -> zero_code=101, cal_done=1; then meas_code=141, meas_delta=+40, meas_valid high exactly 1 cycle.
- Continue with ad_data=80 constant -> after 2 GAP strobes, next measurement gives meas_code=80, meas_delta=-21 (9'h1EB); valid spacing = 4 strobes = 16 sys_clk.
- recal pulse during MEAS, inputs 60 x4 -> measurement completes, GAP, then CAL; zero_code stays 101 until it becomes 60; cal_done never drops.
- start dropped on the strobe cycle completing a measurement -> no meas_valid, IDLE next cycle; restart goes straight to MEAS (cal_done=1).
- sys_rst_n=0 for one cycle mid-CAL -> all outputs 0 next cycle, cal_done=0; restart recalibrates.
